// File: rtl/instr_ctrl_fsm.sv
// Moore control FSM sequencing the register-file/ALU datapath for MOV/ADD/CMP/AND/MVN.
// Optional ILLEGAL_TRAP_EN: illegal codes park the FSM in TRAP until reset.
module instr_ctrl_fsm #(
    parameter bit S_REARM = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_DECODE,
        ST_WRITE_IMM,
        ST_GET_A,
        ST_GET_B,
        ST_ALU,
        ST_STATUS,
        ST_WRITE_REG
`ifdef ILLEGAL_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

    localparam logic [4:0] C_MOV_IMM = 5'b110_10;
    localparam logic [4:0] C_MOV_SH  = 5'b110_00;
    localparam logic [4:0] C_ADD     = 5'b101_00;
    localparam logic [4:0] C_CMP     = 5'b101_01;
    localparam logic [4:0] C_AND     = 5'b101_10;
    localparam logic [4:0] C_MVN     = 5'b101_11;

    state_t      r_state;
    logic [13:0] r_out;
    logic [4:0]  r_code;
    logic        r_rearm;
    logic        w_start;
    logic        w_neg;
    logic [4:0]  w_code;

    // Output bundle: {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal_op}
    function automatic logic [13:0] f_outs(input state_t st, input logic neg);
        logic [13:0] o;
        o = '0;
        case (st)
            ST_WAIT:      o[13]    = 1'b1;
            ST_WRITE_IMM: begin o[12:10] = 3'b100; o[9:8] = 2'b10; o[1] = 1'b1; end
            ST_GET_A:     begin o[12:10] = 3'b100; o[7] = 1'b1; end
            ST_GET_B:     begin o[12:10] = 3'b001; o[6] = 1'b1; end
            ST_ALU:       begin o[3] = 1'b1; o[5] = neg; end
            ST_STATUS:    o[2]     = 1'b1;
            ST_WRITE_REG: begin o[12:10] = 3'b010; o[1] = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:      o[0]     = 1'b1;
`endif
            default:      o        = '0;
        endcase
        return o;
    endfunction

    assign w_code  = {opcode, op};
    assign w_start = s && (r_rearm || !S_REARM);
    assign w_neg   = (r_code == C_MOV_SH) || (r_code == C_MVN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_out   <= f_outs(ST_WAIT, 1'b0);
            r_code  <= '0;
            r_rearm <= 1'b1;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_start) begin
                        r_state <= ST_DECODE;
                        r_out   <= f_outs(ST_DECODE, 1'b0);
                        r_rearm <= 1'b0;
                    end else if (!s) begin
                        r_rearm <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    // opcode/op are only guaranteed stable up to this edge, so keep a copy
                    r_code <= w_code;
                    case (w_code)
                        C_MOV_IMM: begin
                            r_state <= ST_WRITE_IMM;
                            r_out   <= f_outs(ST_WRITE_IMM, 1'b0);
                        end
                        C_MOV_SH, C_MVN: begin
                            r_state <= ST_GET_B;
                            r_out   <= f_outs(ST_GET_B, 1'b0);
                        end
                        C_ADD, C_AND, C_CMP: begin
                            r_state <= ST_GET_A;
                            r_out   <= f_outs(ST_GET_A, 1'b0);
                        end
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            r_state <= ST_TRAP;
                            r_out   <= f_outs(ST_TRAP, 1'b0);
`else
                            r_state <= ST_WAIT;
                            r_out   <= f_outs(ST_WAIT, 1'b0);
`endif
                        end
                    endcase
                end
                ST_GET_A: begin
                    r_state <= ST_GET_B;
                    r_out   <= f_outs(ST_GET_B, 1'b0);
                end
                ST_GET_B: begin
                    if (r_code == C_CMP) begin
                        r_state <= ST_STATUS;
                        r_out   <= f_outs(ST_STATUS, 1'b0);
                    end else begin
                        r_state <= ST_ALU;
                        r_out   <= f_outs(ST_ALU, w_neg);
                    end
                end
                ST_ALU: begin
                    r_state <= ST_WRITE_REG;
                    r_out   <= f_outs(ST_WRITE_REG, 1'b0);
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                    r_out   <= f_outs(ST_TRAP, 1'b0);
                end
`endif
                default: begin
                    r_state <= ST_WAIT;
                    r_out   <= f_outs(ST_WAIT, 1'b0);
                end
            endcase
        end
    end

    assign {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal_op} = r_out;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Scoreboard bench for instr_ctrl_fsm: expected per-cycle output vectors are queued at issue.
module tb_instr_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       s, s_r;
    logic [2:0] opcode;
    logic [1:0] op;

    logic       w, loada, loadb, asel, bsel, loadc, loads, write, illegal_op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       w_r, loada_r, loadb_r, asel_r, bsel_r, loadc_r, loads_r, write_r, illegal_op_r;
    logic [2:0] nsel_r;
    logic [1:0] vsel_r;

    logic [13:0] obs, obs_r;
    assign obs   = {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal_op};
    assign obs_r = {w_r, nsel_r, vsel_r, loada_r, loadb_r, asel_r, bsel_r, loadc_r, loads_r,
                    write_r, illegal_op_r};

    always #5 clk = ~clk;

    instr_ctrl_fsm #(.S_REARM(1'b0)) u_dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .loadc(loadc), .loads(loads), .write(write), .illegal_op(illegal_op)
    );

    instr_ctrl_fsm #(.S_REARM(1'b1)) u_dut_r (
        .clk(clk), .reset(reset), .s(s_r), .opcode(opcode), .op(op),
        .w(w_r), .nsel(nsel_r), .vsel(vsel_r), .loada(loada_r), .loadb(loadb_r), .asel(asel_r),
        .bsel(bsel_r), .loadc(loadc_r), .loads(loads_r), .write(write_r),
        .illegal_op(illegal_op_r)
    );

    // {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal_op}
    localparam logic [13:0] E_WAIT  = {1'b1, 3'b000, 2'b00, 8'b0000_0000};
    localparam logic [13:0] E_DEC   = {1'b0, 3'b000, 2'b00, 8'b0000_0000};
    localparam logic [13:0] E_WIMM  = {1'b0, 3'b100, 2'b10, 8'b0000_0010};
    localparam logic [13:0] E_GETA  = {1'b0, 3'b100, 2'b00, 8'b1000_0000};
    localparam logic [13:0] E_GETB  = {1'b0, 3'b001, 2'b00, 8'b0100_0000};
    localparam logic [13:0] E_ALU0  = {1'b0, 3'b000, 2'b00, 8'b0000_1000};
    localparam logic [13:0] E_ALU1  = {1'b0, 3'b000, 2'b00, 8'b0010_1000};
    localparam logic [13:0] E_STAT  = {1'b0, 3'b000, 2'b00, 8'b0000_0100};
    localparam logic [13:0] E_WREG  = {1'b0, 3'b010, 2'b00, 8'b0000_0010};
    localparam logic [13:0] E_TRAP  = {1'b0, 3'b000, 2'b00, 8'b0000_0001};

    logic [13:0] q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void push_model(input logic [4:0] code);
        q.push_back(E_DEC);
        case (code)
            5'b110_10: begin q.push_back(E_WIMM); end
            5'b110_00, 5'b101_11: begin
                q.push_back(E_GETB); q.push_back(E_ALU1); q.push_back(E_WREG);
            end
            5'b101_00, 5'b101_10: begin
                q.push_back(E_GETA); q.push_back(E_GETB); q.push_back(E_ALU0); q.push_back(E_WREG);
            end
            5'b101_01: begin
                q.push_back(E_GETA); q.push_back(E_GETB); q.push_back(E_STAT);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) q.push_back(E_TRAP);
                return;
`endif
            end
        endcase
        q.push_back(E_WAIT);
    endfunction

    task automatic start(input logic [4:0] code);
        @(negedge clk);
        s = 1'b1;
        {opcode, op} = code;
        push_model(code);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            s = 1'b0;
            chk(tag, {18'd0, obs}, {18'd0, q.pop_front()});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int wcnt, wcnt_r;

    initial begin
        reset = 1'b1; s = 1'b0; s_r = 1'b0; opcode = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {18'd0, obs}, {18'd0, E_WAIT});
        chk("reset_state_r", {18'd0, obs_r}, {18'd0, E_WAIT});
        @(negedge clk);
        reset = 1'b0;

        start(5'b110_10); drain("mov_imm", 100);
        start(5'b110_00); drain("mov_sh", 100);
        start(5'b101_00); drain("add", 100);
        start(5'b101_10); drain("and", 100);
        start(5'b101_01); drain("cmp", 100);
        start(5'b101_11); drain("mvn", 100);

        // Asynchronous reset in the middle of GET_B of an ADD
        start(5'b101_00);
        drain("add_pre_rst", 3);
        #2 reset = 1'b1;
        #1 chk("rst_async", {18'd0, obs}, {18'd0, E_WAIT});
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_no_write", {18'd0, obs}, {18'd0, E_WAIT});
        end

        // s held high for 20 cycles on both instances
        do_reset();
        s = 1'b1; s_r = 1'b1; {opcode, op} = 5'b110_10;
        wcnt = 0; wcnt_r = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            wcnt += int'(write);
            wcnt_r += int'(write_r);
        end
        chk("norearm_count", wcnt, 7);
        chk("rearm_count", wcnt_r, 1);
        chk("rearm_idle", {18'd0, obs_r}, {18'd0, E_WAIT});
        @(negedge clk); s_r = 1'b0;
        @(negedge clk); s_r = 1'b1;
        wcnt_r = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wcnt_r += int'(write_r);
        end
        chk("rearm_second", wcnt_r, 1);
        s = 1'b0; s_r = 1'b0;

        // Illegal instruction
        do_reset();
        start(5'b111_00); drain("illegal", 100);
`ifdef ILLEGAL_TRAP_EN
        @(negedge clk); s = 1'b1;
        @(posedge clk); #1;
        chk("trap_ignores_s", {18'd0, obs}, {18'd0, E_TRAP});
        s = 1'b0;
`endif
        do_reset();
        #1 chk("post_reset", {18'd0, obs}, {18'd0, E_WAIT});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
